// File: rtl/core_bus_pkg.sv
// Shared types for the core-side bus arbiter: owner and FSM state encodings.
package core_bus_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/bus_if.sv
// Simple valid/ready memory bus; the instruction side only uses the read subset.
interface bus_if;
  logic        valid;
  logic [31:0] addr;
  logic        write;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, write, wdata, wstrb, input ready, rdata);
  modport slave (input valid, addr, write, wdata, wstrb, output ready, rdata);
  modport slave_rdonly (input valid, addr, output ready, rdata);
endinterface

// File: rtl/core_arb_select.sv
// Combinational owner choice for the arbiter: round-robin or data-priority with
// a starvation escape for the instruction port.
module core_arb_select
  import core_bus_pkg::*;
#(
  parameter int DATA_PRIO    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    i_vld,
  input  logic                    d_vld,
  input  owner_t                  last_owner,
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
  output owner_t                  owner,
  output logic                    tie
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  always_comb begin
    owner = OWN_I;
    tie   = i_vld && d_vld;
    if (tie) begin
      if (DATA_PRIO != 0) begin
        owner = (starve_cnt >= LIMIT) ? OWN_I : OWN_D;
      end else begin
        owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
      end
    end else if (d_vld) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Two-to-one arbiter merging the core's instruction and data ports onto one
// memory bus; registered grant, one outstanding transfer, bubble between grants.
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int DATA_PRIO    = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  bus_if.slave_rdonly instr_bus,
  bus_if.slave        data_bus,
  bus_if.master       mem_bus
);

  arb_state_t              state_q, state_d;
  owner_t                  owner_q, owner_d;
  owner_t                  last_owner_q, last_owner_d;
  owner_t                  sel_owner;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    tie;
  logic                    own_vld;
  logic                    req_vld;
  logic                    own_i;
  logic                    own_d;

  core_arb_select #(
    .DATA_PRIO   (DATA_PRIO),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .i_vld     (instr_bus.valid),
    .d_vld     (data_bus.valid),
    .last_owner(last_owner_q),
    .starve_cnt(starve_cnt_q),
    .owner     (sel_owner),
    .tie       (tie)
  );

  // Request is live only while the owner keeps valid up, so a dropped valid aborts.
  always_comb begin
    own_vld = (owner_q == OWN_I) ? instr_bus.valid : data_bus.valid;
    req_vld = (state_q == ARB_BUSY) && own_vld;
    own_i   = req_vld && (owner_q == OWN_I);
    own_d   = req_vld && (owner_q == OWN_D);
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (instr_bus.valid || data_bus.valid) begin
          state_d = ARB_BUSY;
          owner_d = sel_owner;
          if (sel_owner == OWN_I) begin
            starve_cnt_d = '0;
          end else if (tie && (starve_cnt_q != '1)) begin
            starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
          end
        end
      end
      ARB_BUSY: begin
        if (!own_vld) begin
          state_d = ARB_IDLE;
        end else if (mem_bus.ready) begin
          state_d      = ARB_IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_D;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign mem_bus.valid = req_vld;
  assign mem_bus.addr  = own_i ? instr_bus.addr : (own_d ? data_bus.addr : '0);
  assign mem_bus.write = own_d && data_bus.write;
  assign mem_bus.wdata = own_d ? data_bus.wdata : '0;
  assign mem_bus.wstrb = own_d ? data_bus.wstrb : '0;

  // Memory response goes to the owner only; rdata is zero whenever ready is low.
  assign instr_bus.ready = own_i && mem_bus.ready;
  assign instr_bus.rdata = (own_i && mem_bus.ready) ? mem_bus.rdata : '0;
  assign data_bus.ready  = own_d && mem_bus.ready;
  assign data_bus.rdata  = (own_d && mem_bus.ready) ? mem_bus.rdata : '0;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: data-priority instance under a scoreboard plus a
// round-robin instance for the alternation pattern.
module tb_core_bus_arbiter;

  localparam int A_PRIO  = 1;
  localparam int A_LIMIT = 2;

  logic clk;
  logic rst;

  bus_if ia ();
  bus_if da ();
  bus_if ma ();
  bus_if ib ();
  bus_if db ();
  bus_if mb ();

  core_bus_arbiter #(.DATA_PRIO(A_PRIO), .STARVE_LIMIT(A_LIMIT)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .instr_bus(ia),
    .data_bus (da),
    .mem_bus  (ma)
  );

  core_bus_arbiter #(.DATA_PRIO(0), .STARVE_LIMIT(4)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .instr_bus(ib),
    .data_bus (db),
    .mem_bus  (mb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory model for instance A: random or fixed wait states, random idle ready.
  int          mem_wait = 0;
  bit          force_rd = 0;
  logic [31:0] rd_val   = 32'h0;

  initial begin
    bit prev_v;
    int wcnt;
    int wtarget;
    prev_v   = 0;
    wcnt     = 0;
    wtarget  = 0;
    ma.ready = 1'b0;
    ma.rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (ma.valid) begin
        if (!prev_v) begin
          wcnt    = 0;
          wtarget = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
        end else begin
          wcnt++;
        end
        ma.ready = (wcnt >= wtarget);
      end else begin
        ma.ready = 1'($urandom_range(0, 1));
      end
      prev_v   = ma.valid;
      ma.rdata = force_rd ? rd_val : $urandom();
    end
  end

  // Reference model and scoreboard for instance A.
  typedef struct {
    bit          own_d;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  txn_t exp_q[$];
  bit   m_busy;
  bit   m_own_d;
  bit   m_last_d;
  int   m_starve;
  bit   i_hs;
  bit   d_hs;

  function automatic bit model_pick_d(input bit iv, input bit dv);
    if (iv && !dv) return 1'b0;
    if (dv && !iv) return 1'b1;
    if (A_PRIO != 0) return !(m_starve >= A_LIMIT);
    return !m_last_d;
  endfunction

  initial begin
    txn_t t;
    bit   ov;
    bit   pick;
    m_busy   = 0;
    m_own_d  = 0;
    m_last_d = 1;
    m_starve = 0;
    i_hs     = 0;
    d_hs     = 0;
    forever begin
      @(negedge clk);
      i_hs = ia.valid && ia.ready;
      d_hs = da.valid && da.ready;
      if (!rst) begin
        check1("rst_mem_valid", ma.valid, 1'b0);
        m_busy   = 0;
        m_last_d = 1;
        m_starve = 0;
        exp_q.delete();
      end else begin
        ov = m_busy && (m_own_d ? da.valid : ia.valid);
        check1("mem_valid", ma.valid, ov);
        if (ma.valid) begin
          check1("exp_pending", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            t = exp_q[0];
            check("mem_addr", ma.addr, t.addr);
            check1("mem_write", ma.write, t.wr);
            check("mem_wstrb", 32'(ma.wstrb), 32'(t.wstrb));
            if (t.own_d) check("mem_wdata", ma.wdata, t.wdata);
            if (ma.ready) begin
              check1("i_ready_route", ia.ready, !t.own_d);
              check1("d_ready_route", da.ready, t.own_d);
              check("i_rdata_route", ia.rdata, t.own_d ? 32'h0 : ma.rdata);
              check("d_rdata_route", da.rdata, t.own_d ? ma.rdata : 32'h0);
              void'(exp_q.pop_front());
            end
          end
        end
        if (!(ma.valid && ma.ready)) begin
          check("no_ready", {30'h0, ia.ready, da.ready}, 32'h0);
          check("no_rdata", ia.rdata | da.rdata, 32'h0);
        end
        if (!m_busy) begin
          if (ia.valid || da.valid) begin
            pick = model_pick_d(ia.valid, da.valid);
            if (!pick) m_starve = 0;
            else if (ia.valid) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
            t.own_d = pick;
            t.addr  = pick ? da.addr : ia.addr;
            t.wr    = pick ? da.write : 1'b0;
            t.wdata = pick ? da.wdata : 32'h0;
            t.wstrb = pick ? da.wstrb : 4'h0;
            exp_q.push_back(t);
            m_own_d = pick;
            m_busy  = 1;
          end
        end else if (!(m_own_d ? da.valid : ia.valid)) begin
          m_busy = 0;
        end else if (ma.ready) begin
          m_busy   = 0;
          m_last_d = m_own_d;
        end
      end
    end
  end

  task automatic rand_step(input bit issue);
    if (ia.valid && i_hs) ia.valid = 1'b0;
    if (da.valid && d_hs) da.valid = 1'b0;
    if (issue && !ia.valid && $urandom_range(0, 99) < 55) begin
      ia.addr  = $urandom() & 32'hFFFF_FFFC;
      ia.valid = 1'b1;
    end
    if (issue && !da.valid && $urandom_range(0, 99) < 55) begin
      da.addr  = $urandom() & 32'hFFFF_FFFC;
      da.write = 1'($urandom_range(0, 1));
      da.wdata = $urandom();
      da.wstrb = da.write ? 4'($urandom_range(1, 15)) : 4'h0;
      da.valid = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  vcyc;
    int  dpulse;
    int  ipulse;
    bit  seen;
    bit  found;
    bit  exp_d;
    rst      = 1'b0;
    ia.write = 1'b0; ia.wdata = 32'h0; ia.wstrb = 4'h0;
    ib.write = 1'b0; ib.wdata = 32'h0; ib.wstrb = 4'h0;
    db.write = 1'b0; db.wdata = 32'h0; db.wstrb = 4'h0;
    mb.ready = 1'b1; mb.rdata = 32'h1234_5678;
    ia.valid = 1'b1; ia.addr = 32'h0000_0100;
    da.valid = 1'b1; da.addr = 32'h2000_0000; da.write = 1'b0; da.wdata = 32'h0; da.wstrb = 4'h0;
    ib.valid = 1'b1; ib.addr = 32'h0000_0200;
    db.valid = 1'b1; db.addr = 32'h2000_0100;

    repeat (3) @(posedge clk);
    #1;
    check1("rst_a_valid", ma.valid, 1'b0);
    check1("rst_a_write", ma.write, 1'b0);
    check("rst_a_wstrb", 32'(ma.wstrb), 32'h0);
    check("rst_a_addr", ma.addr, 32'h0);
    check("rst_a_wdata", ma.wdata, 32'h0);
    check("rst_a_ready", {30'h0, ia.ready, da.ready}, 32'h0);
    check("rst_a_rdata", ia.rdata | da.rdata, 32'h0);
    check1("rst_b_valid", mb.valid, 1'b0);
    check("rst_b_addr", mb.addr, 32'h0);
    check("rst_b_ready", {30'h0, ib.ready, db.ready}, 32'h0);
    check("rst_b_rdata", ib.rdata | db.rdata, 32'h0);
    rst = 1'b1;

    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      check1("rr_i_ready", ib.ready, (c % 4) == 1);
      check1("rr_d_ready", db.ready, (c % 4) == 3);
      if (c == 1) check("rr_first_addr", mb.addr, ib.addr);
      if ((c % 2) == 1) begin
        exp_d = ((c / 2) % 3) != 2;
        check1("prio_order_d", da.ready, exp_d);
        check1("prio_order_i", ia.ready, !exp_d);
      end
    end

    @(posedge clk);
    #1;
    rst = 1'b0;
    ia.valid = 1'b0; da.valid = 1'b0; ib.valid = 1'b0; db.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Data write with three memory wait states.
    mem_wait = 3;
    @(posedge clk);
    #1;
    da.addr = 32'h2000_0010; da.write = 1'b1; da.wdata = 32'hDEAD_BEEF; da.wstrb = 4'h3;
    da.valid = 1'b1;
    vcyc = 0; dpulse = 0; ipulse = 0;
    repeat (10) begin
      @(negedge clk);
      if (ma.valid) begin
        vcyc++;
        check("wr_addr", ma.addr, 32'h2000_0010);
        check1("wr_write", ma.write, 1'b1);
        check("wr_wdata", ma.wdata, 32'hDEAD_BEEF);
        check("wr_wstrb", 32'(ma.wstrb), 32'h3);
      end
      if (ia.ready) ipulse++;
      if (da.ready) begin
        dpulse++;
        @(posedge clk);
        #1;
        da.valid = 1'b0;
      end
    end
    check("wr_valid_cycles", vcyc, 4);
    check("wr_d_pulses", dpulse, 1);
    check("wr_i_pulses", ipulse, 0);

    // Instruction read while the data port shows write fields but no valid.
    mem_wait = 0;
    force_rd = 1;
    rd_val   = 32'h0000_0013;
    @(posedge clk);
    #1;
    da.addr = 32'h2000_0020; da.write = 1'b1; da.wdata = 32'hFFFF_FFFF; da.wstrb = 4'hF;
    ia.addr = 32'h0000_0400; ia.valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (ma.valid) begin
        check1("ird_write", ma.write, 1'b0);
        check("ird_wstrb", 32'(ma.wstrb), 32'h0);
        check("ird_addr", ma.addr, 32'h0000_0400);
      end
      if (ia.ready) begin
        seen = 1;
        check("ird_rdata", ia.rdata, 32'h0000_0013);
        check1("ird_d_ready", da.ready, 1'b0);
        check("ird_d_rdata", da.rdata, 32'h0);
      end
    end
    check1("ird_done", seen, 1'b1);
    @(posedge clk);
    #1;
    ia.valid = 1'b0;
    force_rd = 0;

    // Reset asserted in the second BUSY cycle of a slow read.
    mem_wait = 3;
    @(posedge clk);
    #1;
    da.addr = 32'h3000_0000; da.write = 1'b0; da.wdata = 32'h0; da.wstrb = 4'h0;
    da.valid = 1'b1;
    found = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (ma.valid) found = 1;
    end
    check1("rb_busy_seen", found, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check1("rb_valid_drop", ma.valid, 1'b0);
    check("rb_ready_drop", {30'h0, ia.ready, da.ready}, 32'h0);
    da.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rb_no_spurious", {29'h0, ma.valid, ia.ready, da.ready}, 32'h0);
    end
    mem_wait = 0;
    @(posedge clk);
    #1;
    ia.addr = 32'h0000_0040; ia.valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (ia.ready) seen = 1;
    end
    check1("rb_restart", seen, 1'b1);
    @(posedge clk);
    #1;
    ia.valid = 1'b0;

    // Randomized traffic with random wait states.
    mem_wait = -1;
    repeat (3000) begin
      @(posedge clk);
      #1;
      rand_step(1'b1);
    end
    for (int k = 0; k < 100 && (ia.valid || da.valid); k++) begin
      @(posedge clk);
      #1;
      rand_step(1'b0);
    end
    check1("drain_done", ia.valid || da.valid, 1'b0);
    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
# core_bus_arbiter

Two-to-one bus arbiter that sits directly downstream of the CPU core. It merges the core's read-only instruction port and read/write data port onto a single memory-side bus. Arbitration is registered and allows one outstanding transaction. Instruction starvation is bounded even when data has priority.

## Interface

Parameters:
- DATA_PRIO, 0, arbitration mode: 0 = round-robin, 1 = data wins ties, subject to STARVE_LIMIT.
- STARVE_LIMIT, 4, consecutive lost instruction arbitrations after which the instruction port wins the next tie (DATA_PRIO=1 only); range 1..15.

Ports:
- clk  in  1  core clock; everything sampled on rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_bus  bus_if.slave_rdonly  —  instruction requester: valid, addr[31:0] in; ready, rdata[31:0] out.
- data_bus  bus_if.slave  —  data requester: valid, addr[31:0], write, wdata[31:0], wstrb[3:0] in; ready, rdata[31:0] out.
- mem_bus  bus_if.master  —  memory side, same signal set as data_bus.

Bus protocol: a requester holds valid and all request fields stable until it samples ready=1. The transfer completes in the cycle where valid=1 and ready=1, and rdata is valid in that cycle only.

## Operation

- FSM states: IDLE, BUSY. Registers: owner (I/D), last_owner, starve_cnt[3:0].
- IDLE:
  - mem_bus.valid=0 and both ready outputs are 0.
  - If any valid request is present, latch owner and go to BUSY.
- Owner selection:
  - Only one requester valid: that one wins.
  - Both valid, DATA_PRIO=0: the port that is not last_owner wins.
  - Both valid, DATA_PRIO=1: data wins unless starve_cnt ≥ STARVE_LIMIT, in which case instruction wins.
- starve_cnt:
  - Increments (saturating at 15) each time instruction loses a tie.
  - Clears when instruction is granted.
- BUSY:
  - mem_bus request fields are driven combinationally from the owner.
  - An instruction owner forces write=0 and wstrb=0.
  - mem_bus.ready and mem_bus.rdata are routed only to the owner; the non-owner's ready is 0.
- Completion (mem_bus.ready=1 in BUSY): last_owner←owner, next state IDLE.
- Owner drops valid before ready (protocol violation): mem_bus.valid drops with it, and the FSM returns to IDLE next cycle.
- mem_bus.ready=1 while mem_bus.valid=0 is ignored.

## Timing

- Reset values:
  - state=IDLE, owner=I, last_owner=D, starve_cnt=0.
  - All outputs 0: mem_bus.valid, write, wstrb, addr, wdata, instr_bus.ready, data_bus.ready.
  - rdata outputs read 0 while ready=0.
- Latency: request valid in cycle N (IDLE) → mem_bus.valid in cycle N+1. With a zero-wait memory, ready returns in N+1, giving a minimum 2-cycle transaction.
- Throughput: one bubble cycle (IDLE) between consecutive transactions, so the peak rate is one transfer per 2 cycles.
- Reset asserted mid-BUSY: mem_bus.valid drops immediately (asynchronously), and the in-flight memory response is discarded.
- New requests arriving during BUSY wait. There is no preemption.

## Structure

- Shared package core_bus_pkg holds: the owner_t enum (OWN_I, OWN_D), the arb_state_t enum (ARB_IDLE, ARB_BUSY), and the STARVE_CNT_W=4 constant.
- One natural sub-module: core_arb_select, a combinational owner choice from the two valid bits, last_owner, starve_cnt and DATA_PRIO.
- Instantiation point: core_cpu. instr_bus and data_bus feed this block, and mem_bus becomes the single external port.

## Test plan

- Reset with both valid=1 → all outputs 0. After rst release, the first grant goes to I (last_owner=D) and mem_bus.addr equals instr addr in the next cycle.
- DATA_PRIO=0, both requesters continuously valid, memory ready every cycle → grants alternate I,D,I,D. Each port completes once per 4 cycles.
- DATA_PRIO=1, STARVE_LIMIT=2, both continuously valid → grant order D,D,I,D,D,I, with starve_cnt going 1,2,0.
- Data write addr=0x2000_0010, wdata=0xDEADBEEF, wstrb=0x3, memory with 3 wait states:
  - mem_bus fields stay stable for 4 cycles.
  - data_bus.ready pulses once.
  - instr_bus.ready stays 0 throughout.
- Instruction read while data_bus presents write=1 → mem_bus.write=0 and wstrb=0. The returned rdata=0x00000013 reaches instr_bus only.
- rst asserted in the second BUSY cycle → mem_bus.valid=0 in the same cycle. After release, arbitration restarts from IDLE with no spurious ready.
